// File: rtl/clock_seg_scan.sv
// clock_seg_scan: multiplexed 4-digit common-anode seven-segment driver for a
// 12-hour clock. Hours/minutes/colon are snapshotted once per frame so a value
// never tears across digits; every digit slot begins with a blank interval.
// Optional build macro: HOUR_TENS_BLANK_EN (suppress the leading hours-tens zero).
module clock_seg_scan #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic       colon,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] SNAP_CNT  = CW'(BLANK_CYCLES - 1);
  localparam logic [6:0]    SEG_OFF   = 7'b1111111;
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    d, d_next;
  logic [3:0]    hours_sh, hours_nx;
  logic [5:0]    minutes_sh, minutes_nx;
  logic          colon_sh, colon_nx;
  logic          snap;
  logic          valid;
  logic [3:0]    min_tens, min_ones, hr_ones, digit;
  logic          hr_tens;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic [3:0]    an_next;

  // Active-low {g..a} pattern for a decimal digit.
  function automatic logic [6:0] seven_seg(input logic [3:0] v);
    case (v)
      4'd0:    seven_seg = 7'b1000000;
      4'd1:    seven_seg = 7'b1111001;
      4'd2:    seven_seg = 7'b0100100;
      4'd3:    seven_seg = 7'b0110000;
      4'd4:    seven_seg = 7'b0011001;
      4'd5:    seven_seg = 7'b0010010;
      4'd6:    seven_seg = 7'b0000010;
      4'd7:    seven_seg = 7'b1111000;
      4'd8:    seven_seg = 7'b0000000;
      4'd9:    seven_seg = 7'b0010000;
      default: seven_seg = SEG_DASH;
    endcase
  endfunction

  // Slot counter, digit index and blank/show state for the upcoming cycle.
  always_comb begin
    cnt_next = cnt + 1'b1;
    d_next   = d;
    if (cnt == CNT_LAST) begin
      cnt_next = '0;
      d_next   = d + 2'd1;
    end
    state_next = state;
    if (state == BLANK && cnt_next == BLANK_END) state_next = SHOW;
    if (state == SHOW && cnt_next == '0)        state_next = BLANK;
  end

  // Shadow values take the live inputs on the last blank cycle before digit 0.
  always_comb begin
    snap       = (d == 2'd0) && (cnt == SNAP_CNT);
    hours_nx   = snap ? hours   : hours_sh;
    minutes_nx = snap ? minutes : minutes_sh;
    colon_nx   = snap ? colon   : colon_sh;
  end

  // Binary-to-decimal split by compare/subtract, then pick the digit in view.
  always_comb begin
    valid = (hours_nx != 4'd0) && (hours_nx <= 4'd12) && (minutes_nx <= 6'd59);
    if (minutes_nx >= 6'd50) begin
      min_tens = 4'd5; min_ones = 4'(minutes_nx - 6'd50);
    end else if (minutes_nx >= 6'd40) begin
      min_tens = 4'd4; min_ones = 4'(minutes_nx - 6'd40);
    end else if (minutes_nx >= 6'd30) begin
      min_tens = 4'd3; min_ones = 4'(minutes_nx - 6'd30);
    end else if (minutes_nx >= 6'd20) begin
      min_tens = 4'd2; min_ones = 4'(minutes_nx - 6'd20);
    end else if (minutes_nx >= 6'd10) begin
      min_tens = 4'd1; min_ones = 4'(minutes_nx - 6'd10);
    end else begin
      min_tens = 4'd0; min_ones = minutes_nx[3:0];
    end
    hr_tens = (hours_nx >= 4'd10);
    hr_ones = hr_tens ? (hours_nx - 4'd10) : hours_nx;
    case (d_next)
      2'd0:    digit = min_ones;
      2'd1:    digit = min_tens;
      2'd2:    digit = hr_ones;
      default: digit = {3'b000, hr_tens};
    endcase
  end

  // Next registered anode/cathode drive; blank slots keep everything dark.
  always_comb begin
    an_next  = 4'b1111;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (state_next == SHOW) begin
      an_next[d_next] = 1'b0;
      if (!valid) begin
        seg_next = SEG_DASH;
      end else begin
        seg_next = seven_seg(digit);
        if (d_next == 2'd2) dp_next = ~colon_nx;
      end
`ifdef HOUR_TENS_BLANK_EN
      if (valid && d_next == 2'd3 && !hr_tens) begin
        an_next  = 4'b1111;
        seg_next = SEG_OFF;
      end
`else
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state <= BLANK;
    else       state <= state_next;
  end

  // Counters, shadow registers and registered display outputs.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      d          <= 2'd0;
      hours_sh   <= 4'd0;
      minutes_sh <= 6'd0;
      colon_sh   <= 1'b0;
      an         <= 4'b1111;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
    end else begin
      cnt        <= cnt_next;
      d          <= d_next;
      hours_sh   <= hours_nx;
      minutes_sh <= minutes_nx;
      colon_sh   <= colon_nx;
      an         <= an_next;
      seg        <= seg_next;
      dp         <= dp_next;
    end
  end

endmodule

// File: tb/tb_clock_seg_scan.sv
// Self-checking bench for clock_seg_scan with REFRESH_DIV = 8, BLANK_CYCLES = 2.
// Honours HOUR_TENS_BLANK_EN when the same macro is defined for the build.
module tb_clock_seg_scan;

  localparam int RD = 8;
  localparam int BC = 2;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S9 = 7'b0010000, SD = 7'b0111111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] hours = 4'd0;
  logic [5:0] minutes = 6'd0;
  logic       colon = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int assert_count = 0;
  int fail_count = 0;
  int cyc = 0;
  logic [3:0] prev_an = 4'b1111;

  typedef struct {
    logic [3:0]  hours;
    logic [5:0]  minutes;
    logic        colon;
    logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  dps;
    bit          tens_zero;
    int          frames;
  } vec_t;

  vec_t vecs[9];

  clock_seg_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk_100MHz(clk), .reset(reset), .hours(hours), .minutes(minutes),
    .colon(colon), .seg(seg), .dp(dp), .an(an)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] h, input logic [5:0] m, input logic c);
    hours = h; minutes = m; colon = c;
  endtask

  // Pulse reset (checking the asynchronous clear) and restart the cycle count.
  task automatic doReset();
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'h1);
    @(posedge clk); #1 reset = 1'b0;
    cyc = 0;
    prev_an = 4'b1111;
  endtask

  // Advance one clock and compare outputs with the expected slot pattern.
  task automatic checkOutput(input logic [27:0] segs, input logic [3:0] dps, input bit tz);
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    int c, d;
    @(posedge clk); #1;
    cyc++;
    c = cyc % RD;
    d = (cyc / RD) % 4;
    ean = 4'b1111; eseg = 7'h7F; edp = 1'b1;
    if (c >= BC) begin
      ean[d] = 1'b0;
      eseg = segs[7*d +: 7];
      edp = dps[d];
`ifdef HOUR_TENS_BLANK_EN
      if (d == 3 && tz) begin
        ean = 4'b1111; eseg = 7'h7F;
      end
`else
      if (tz && d == 3) eseg = S0;
`endif
    end
    check("an", 32'(an), 32'(ean));
    check("seg", 32'(seg), 32'(eseg));
    check("dp", 32'(dp), 32'(edp));
    check("one_anode", 32'($countones(~an) <= 1), 32'h1);
    check("no_direct_hop", 32'(prev_an == 4'b1111 || an == 4'b1111 || an == prev_an), 32'h1);
    prev_an = an;
  endtask

  initial begin
    vecs[0] = '{4'd12, 6'd34, 1'b1, {S1, S2, S3, S4}, 4'b1011, 1'b0, 3};
    vecs[1] = '{4'd9,  6'd5,  1'b0, {S0, S9, S0, S5}, 4'b1111, 1'b1, 1};
    vecs[2] = '{4'd10, 6'd59, 1'b1, {S1, S0, S5, S9}, 4'b1011, 1'b0, 1};
    vecs[3] = '{4'd1,  6'd0,  1'b1, {S0, S1, S0, S0}, 4'b1011, 1'b1, 1};
    vecs[4] = '{4'd13, 6'd0,  1'b1, {SD, SD, SD, SD}, 4'b1111, 1'b0, 1};
    vecs[5] = '{4'd12, 6'd60, 1'b0, {SD, SD, SD, SD}, 4'b1111, 1'b0, 1};
    vecs[6] = '{4'd0,  6'd0,  1'b1, {SD, SD, SD, SD}, 4'b1111, 1'b0, 1};
    vecs[7] = '{4'd11, 6'd7,  1'b0, {S1, S1, S0, S7}, 4'b1111, 1'b0, 1};
    vecs[8] = '{4'd15, 6'd59, 1'b1, {SD, SD, SD, SD}, 4'b1111, 1'b0, 1};

    // Table-driven frames: inputs steady from reset onward.
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].hours, vecs[v].minutes, vecs[v].colon);
      doReset();
      for (int i = 0; i < vecs[v].frames * 4 * RD; i++)
        checkOutput(vecs[v].segs, vecs[v].dps, vecs[v].tens_zero);
    end

    // Minutes change 34 -> 35 while digit 2 is lit: no effect until next frame.
    applyStimulus(4'd12, 6'd34, 1'b1);
    doReset();
    for (int i = 0; i < 2 * RD + 3; i++) checkOutput({S1, S2, S3, S4}, 4'b1011, 1'b0);
    minutes = 6'd35;
    for (int i = 2 * RD + 3; i < 4 * RD; i++) checkOutput({S1, S2, S3, S4}, 4'b1011, 1'b0);
    for (int i = 0; i < 4 * RD; i++) checkOutput({S1, S2, S3, S5}, 4'b1011, 1'b0);

    // Change during digit 0 after the snapshot: rest of frame keeps old value.
    doReset();
    for (int i = 0; i < BC + 1; i++) checkOutput({S1, S2, S3, S5}, 4'b1011, 1'b0);
    applyStimulus(4'd9, 6'd5, 1'b0);
    for (int i = BC + 1; i < 4 * RD; i++) checkOutput({S1, S2, S3, S5}, 4'b1011, 1'b0);
    for (int i = 0; i < 4 * RD; i++) checkOutput({S0, S9, S0, S5}, 4'b1111, 1'b1);

    // Reset asserted mid-SHOW of digit 1 clears outputs immediately.
    applyStimulus(4'd12, 6'd34, 1'b1);
    doReset();
    for (int i = 0; i < RD + 4; i++) checkOutput({S1, S2, S3, S4}, 4'b1011, 1'b0);
    check("d1_lit_before_reset", 32'(an), 32'b1101);
    #2 reset = 1'b1;
    #1;
    check("midslot_reset_an", 32'(an), 32'hF);
    check("midslot_reset_seg", 32'(seg), 32'h7F);
    check("midslot_reset_dp", 32'(dp), 32'h1);
    @(posedge clk); #1 reset = 1'b0;
    cyc = 0;
    prev_an = 4'b1111;
    for (int i = 0; i < 4 * RD; i++) checkOutput({S1, S2, S3, S4}, 4'b1011, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
